// File: rtl/seg7_scan_capture.sv
// Recovers the hex nibble shown on each digit of a multiplexed 7-segment bus.
// Define SEG7_SCAN_CAPTURE_DP_EN to track and capture the decimal point as well.

module seg7_scan_capture #(
  parameter int unsigned N_DIGITS      = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic [6:0]                                        seg_in,
  input  logic                                              dp_in,
  input  logic [N_DIGITS-1:0]                               dig_en,
  input  logic                                              clr,
  output logic [4*N_DIGITS-1:0]                             value,
  output logic [N_DIGITS-1:0]                               digit_valid,
  output logic                                              upd,
  output logic [((N_DIGITS > 1) ? $clog2(N_DIGITS) : 1)-1:0] upd_idx,
  output logic                                              err,
  output logic [N_DIGITS-1:0]                               dp_out
);

  localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned CntW = 8;
`ifdef SEG7_SCAN_CAPTURE_DP_EN
  localparam int unsigned TupW = N_DIGITS + 8;
`else
  localparam int unsigned TupW = N_DIGITS + 7;
`endif

  typedef enum logic [1:0] {StIdle, StTrack, StHold} state_e;

  // Returns {is_hex, nibble}; blank and invalid codes both give is_hex = 0.
  function automatic logic [4:0] decode_glyph(input logic [6:0] s);
    logic [4:0] d;
    case (s)
      7'h3F:   d = {1'b1, 4'h0};
      7'h06:   d = {1'b1, 4'h1};
      7'h5B:   d = {1'b1, 4'h2};
      7'h4F:   d = {1'b1, 4'h3};
      7'h66:   d = {1'b1, 4'h4};
      7'h6D:   d = {1'b1, 4'h5};
      7'h7D:   d = {1'b1, 4'h6};
      7'h07:   d = {1'b1, 4'h7};
      7'h7F:   d = {1'b1, 4'h8};
      7'h6F:   d = {1'b1, 4'h9};
      7'h77:   d = {1'b1, 4'hA};
      7'h7C:   d = {1'b1, 4'hB};
      7'h39:   d = {1'b1, 4'hC};
      7'h5E:   d = {1'b1, 4'hD};
      7'h79:   d = {1'b1, 4'hE};
      7'h71:   d = {1'b1, 4'hF};
      default: d = 5'b0;
    endcase
    return d;
  endfunction

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [TupW-1:0]     smp_q, tup;
  logic                same, onehot, commit;
  logic [3:0]          en_cnt;
  logic [IdxW-1:0]     en_idx;
  logic [4:0]          dec;
  logic                blank;

  logic [4*N_DIGITS-1:0] value_q, value_d;
  logic [N_DIGITS-1:0]   valid_q, valid_d;
  logic                  upd_q, upd_d;
  logic                  err_q, err_d;
  logic [IdxW-1:0]       idx_q, idx_d;

`ifdef SEG7_SCAN_CAPTURE_DP_EN
  logic [N_DIGITS-1:0]   dp_q, dp_d;
  assign tup = {dig_en, seg_in, dp_in};
`else
  logic unused_dp;
  assign unused_dp = dp_in;
  assign tup       = {dig_en, seg_in};
`endif

  assign same    = (tup == smp_q);
  assign cnt_inc = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + 8'd1;
  assign dec     = decode_glyph(seg_in);
  assign blank   = (seg_in == 7'h00);

  always_comb begin
    en_cnt = '0;
    en_idx = '0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (dig_en[i]) begin
        en_cnt = en_cnt + 4'd1;
        en_idx = IdxW'(i);
      end
    end
  end

  assign onehot = (en_cnt == 4'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (onehot) begin
          state_d = StTrack;
          cnt_d   = 8'd1;
        end else begin
          cnt_d   = '0;
        end
      end
      StTrack: begin
        if (!onehot) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (same) begin
          cnt_d   = cnt_inc;
        end else begin
          cnt_d   = 8'd1;
        end
      end
      StHold: begin
        if (!onehot) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (same) begin
          cnt_d   = cnt_inc;
        end else begin
          state_d = StTrack;
          cnt_d   = 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    // Only a tuple still being tracked can commit; HOLD never re-commits.
    if (state_d == StTrack && cnt_d == CntW'(STABLE_CYCLES)) begin
      commit  = 1'b1;
      state_d = StHold;
    end
  end

  always_comb begin
    value_d = value_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    upd_d   = 1'b0;
    err_d   = 1'b0;
`ifdef SEG7_SCAN_CAPTURE_DP_EN
    dp_d    = dp_q;
`endif
    if (clr) begin
      value_d = '0;
      valid_d = '0;
`ifdef SEG7_SCAN_CAPTURE_DP_EN
      dp_d    = '0;
`endif
    end else if (commit) begin
      upd_d = 1'b1;
      idx_d = en_idx;
      if (dec[4]) begin
        value_d[4*int'(en_idx) +: 4] = dec[3:0];
        valid_d[en_idx]              = 1'b1;
`ifdef SEG7_SCAN_CAPTURE_DP_EN
        dp_d[en_idx]                 = dp_in;
`endif
      end else if (blank) begin
        valid_d[en_idx] = 1'b0;
`ifdef SEG7_SCAN_CAPTURE_DP_EN
        dp_d[en_idx]    = dp_in;
`endif
      end else begin
        valid_d[en_idx] = 1'b0;
        err_d           = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      smp_q   <= '0;
      value_q <= '0;
      valid_q <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
`ifdef SEG7_SCAN_CAPTURE_DP_EN
      dp_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      smp_q   <= tup;
      value_q <= value_d;
      valid_q <= valid_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
`ifdef SEG7_SCAN_CAPTURE_DP_EN
      dp_q    <= dp_d;
`endif
    end
  end

  assign value       = value_q;
  assign digit_valid = valid_q;
  assign upd         = upd_q;
  assign err         = err_q;
  assign upd_idx     = idx_q;
`ifdef SEG7_SCAN_CAPTURE_DP_EN
  assign dp_out      = dp_q;
`else
  assign dp_out      = '0;
`endif

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Randomized and directed bench for seg7_scan_capture against a run-length reference model.

module tb_seg7_scan_capture;

  localparam int N = 4;
  localparam int S = 4;
`ifdef SEG7_SCAN_CAPTURE_DP_EN
  localparam bit UseDp = 1'b1;
`else
  localparam bit UseDp = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [6:0]     seg_in = '0;
  logic           dp_in = 1'b0;
  logic [N-1:0]   dig_en = '0;
  logic           clr = 1'b0;
  logic [4*N-1:0] value;
  logic [N-1:0]   digit_valid;
  logic           upd;
  logic [1:0]     upd_idx;
  logic           err;
  logic [N-1:0]   dp_out;

  always #5 clk = ~clk;

  seg7_scan_capture #(
    .N_DIGITS      (N),
    .STABLE_CYCLES (S)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dp_in       (dp_in),
    .dig_en      (dig_en),
    .clr         (clr),
    .value       (value),
    .digit_valid (digit_valid),
    .upd         (upd),
    .upd_idx     (upd_idx),
    .err         (err),
    .dp_out      (dp_out)
  );

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: a commit happens when a one-hot tuple has been seen exactly S times in a row.
  int         m_run;
  logic [N+7:0] m_prev;
  logic [3:0] m_val [N];
  logic [N-1:0] m_valid, m_dp;
  logic       m_upd, m_err;
  int         m_idx;

  int n_vec = 0;
  int n_err = 0;

  task automatic model_reset();
    m_run = 0;
    m_prev = '0;
    for (int k = 0; k < N; k++) m_val[k] = 4'h0;
    m_valid = '0;
    m_dp = '0;
    m_upd = 1'b0;
    m_err = 1'b0;
    m_idx = 0;
  endtask

  function automatic logic [4*N-1:0] model_value();
    logic [4*N-1:0] v;
    for (int k = 0; k < N; k++) v[4*k +: 4] = m_val[k];
    return v;
  endfunction

  task automatic step(input logic [N-1:0] d, input logic [6:0] s, input logic p, input logic c);
    logic [N+7:0] cur;
    bit oh;
    int idx, hit;
    dig_en = d;
    seg_in = s;
    dp_in  = p;
    clr    = c;
    @(posedge clk);
    cur = {d, s, (UseDp ? p : 1'b0)};
    oh  = ($countones(d) == 1);
    if (!oh) m_run = 0;
    else if (cur == m_prev) m_run++;
    else m_run = 1;
    m_prev = cur;
    m_upd = 1'b0;
    m_err = 1'b0;
    if (c) begin
      for (int k = 0; k < N; k++) m_val[k] = 4'h0;
      m_valid = '0;
      m_dp = '0;
    end else if (oh && m_run == S) begin
      idx = 0;
      for (int k = 0; k < N; k++) if (d[k]) idx = k;
      hit = -1;
      for (int k = 0; k < 16; k++) if (glyph[k] == s) hit = k;
      m_upd = 1'b1;
      m_idx = idx;
      if (hit >= 0) begin
        m_val[idx] = 4'(hit);
        m_valid[idx] = 1'b1;
        if (UseDp) m_dp[idx] = p;
      end else if (s == 7'h00) begin
        m_valid[idx] = 1'b0;
        if (UseDp) m_dp[idx] = p;
      end else begin
        m_valid[idx] = 1'b0;
        m_err = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      dig_en = 4'($urandom);
      seg_in = 7'($urandom);
      dp_in  = 1'($urandom);
      clr    = 1'($urandom);
      @(posedge clk);
      #1;
      n_vec++;
      if ({value, digit_valid, upd, err, dp_out, upd_idx} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs: got value=%h valid=%b upd=%b err=%b dp=%b idx=%0d, want all 0",
                 value, digit_valid, upd, err, dp_out, upd_idx);
      end
    end
    clr = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step('0, 7'($urandom), 1'($urandom), 1'b0);
      n_vec++;
      if (upd !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle_no_upd: cycle %0d got upd=%b want 0", i, upd);
      end
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin
      step(4'b0001, 7'h5B, 1'b0, 1'b0);
      n_vec++;
      if (upd !== (i == 3)) begin
        n_err++;
        $display("FAIL basic_upd_timing: edge %0d got upd=%b want %b", i + 1, upd, (i == 3));
      end
    end
    n_vec++;
    if (upd_idx !== 2'd0 || value[3:0] !== 4'h2 || digit_valid !== 4'b0001) begin
      n_err++;
      $display("FAIL basic_commit: got idx=%0d nib=%h valid=%b want idx=0 nib=2 valid=0001",
               upd_idx, value[3:0], digit_valid);
    end
    for (int i = 0; i < 20; i++) begin
      step(4'b0001, 7'h5B, 1'b0, 1'b0);
      n_vec++;
      if (upd !== 1'b0) begin
        n_err++;
        $display("FAIL basic_hold_no_upd: cycle %0d got upd=%b want 0", i, upd);
      end
    end
  endtask

  task automatic test_glitch();
    logic [6:0] seq [7] = '{7'h7F, 7'h7F, 7'h7E, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    for (int i = 0; i < 7; i++) begin
      step(4'b0100, seq[i], 1'b0, 1'b0);
      n_vec++;
      if (upd !== (i == 6)) begin
        n_err++;
        $display("FAIL glitch_upd_timing: edge %0d got upd=%b want %b", i + 1, upd, (i == 6));
      end
    end
    n_vec++;
    if (value[11:8] !== 4'h8 || digit_valid[2] !== 1'b1 || upd_idx !== 2'd2) begin
      n_err++;
      $display("FAIL glitch_commit: got nib=%h valid2=%b idx=%0d want nib=8 valid2=1 idx=2",
               value[11:8], digit_valid[2], upd_idx);
    end
  endtask

  task automatic test_invalid_blank();
    for (int i = 0; i < 4; i++) step(4'b0010, 7'h4F, 1'b0, 1'b0);
    n_vec++;
    if (value[7:4] !== 4'h3 || digit_valid[1] !== 1'b1) begin
      n_err++;
      $display("FAIL invalid_preload: got nib=%h valid1=%b want nib=3 valid1=1",
               value[7:4], digit_valid[1]);
    end
    for (int i = 0; i < 5; i++) begin
      step(4'b0010, 7'h49, 1'b0, 1'b0);
      n_vec++;
      if (err !== (i == 3) || upd !== (i == 3)) begin
        n_err++;
        $display("FAIL invalid_err_pulse: edge %0d got err=%b upd=%b want %b", i + 1, err, upd,
                 (i == 3));
      end
      if (i == 3) begin
        n_vec++;
        if (upd_idx !== 2'd1 || digit_valid[1] !== 1'b0 || value[7:4] !== 4'h3) begin
          n_err++;
          $display("FAIL invalid_state: got idx=%0d valid1=%b nib=%h want idx=1 valid1=0 nib=3",
                   upd_idx, digit_valid[1], value[7:4]);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(4'b0010, 7'h00, 1'b0, 1'b0);
      n_vec++;
      if (upd !== (i == 3) || err !== 1'b0) begin
        n_err++;
        $display("FAIL blank_commit: edge %0d got upd=%b err=%b want upd=%b err=0", i + 1, upd,
                 err, (i == 3));
      end
    end
    n_vec++;
    if (digit_valid[1] !== 1'b0 || value[7:4] !== 4'h3) begin
      n_err++;
      $display("FAIL blank_state: got valid1=%b nib=%h want valid1=0 nib=3", digit_valid[1],
               value[7:4]);
    end
  endtask

  task automatic test_multihot_clr();
    for (int i = 0; i < 10; i++) begin
      step(4'b0011, 7'h06, 1'b0, 1'b0);
      n_vec++;
      if (upd !== 1'b0) begin
        n_err++;
        $display("FAIL multihot_no_upd: cycle %0d got upd=%b want 0", i, upd);
      end
    end
    for (int i = 0; i < 3; i++) step(4'b1000, 7'h06, 1'b0, 1'b0);
    step(4'b1000, 7'h06, 1'b0, 1'b1);
    n_vec++;
    if (value !== '0 || digit_valid !== '0 || upd !== 1'b0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL clr_wins: got value=%h valid=%b upd=%b err=%b want all 0", value,
               digit_valid, upd, err);
    end
    for (int i = 0; i < 4; i++) begin
      step(4'b1000, 7'h06, 1'b0, 1'b0);
      n_vec++;
      if (upd !== 1'b0) begin
        n_err++;
        $display("FAIL clr_then_hold: cycle %0d got upd=%b want 0", i, upd);
      end
    end
  endtask

  task automatic test_full_scan();
    logic [6:0] pat [4] = '{7'h06, 7'h5B, 7'h4F, 7'h66};
    int nupd = 0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 8; i++) begin
        step(4'(1 << k), pat[k], (k == 3), 1'b0);
        if (upd === 1'b1) nupd++;
      end
    end
    n_vec++;
    if (value !== 16'h4321 || digit_valid !== 4'b1111 || nupd != 4) begin
      n_err++;
      $display("FAIL full_scan: got value=%h valid=%b upds=%0d want 4321 1111 4", value,
               digit_valid, nupd);
    end
    n_vec++;
    if (dp_out !== (UseDp ? 4'b1000 : 4'b0000)) begin
      n_err++;
      $display("FAIL full_scan_dp: got dp=%b want %b", dp_out, (UseDp ? 4'b1000 : 4'b0000));
    end
  endtask

  task automatic test_async_reset();
    step(4'b0001, 7'h6D, 1'b0, 1'b0);
    step(4'b0001, 7'h6D, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (value !== '0 || digit_valid !== '0) begin
      n_err++;
      $display("FAIL async_reset: got value=%h valid=%b want 0 0", value, digit_valid);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(4'b0001, 7'h6D, 1'b0, 1'b0);
      n_vec++;
      if (upd !== (i == 3)) begin
        n_err++;
        $display("FAIL reset_discards_count: edge %0d got upd=%b want %b", i + 1, upd, (i == 3));
      end
    end
    n_vec++;
    if (value[3:0] !== 4'h5) begin
      n_err++;
      $display("FAIL reset_recommit: got nib=%h want 5", value[3:0]);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] d;
    logic [6:0]   s;
    logic         p;
    int           dwell;
    int           cyc = 0;
    while (cyc < 600) begin
      if ($urandom_range(0, 9) == 0) d = 4'($urandom);
      else d = 4'(1 << $urandom_range(0, N - 1));
      case ($urandom_range(0, 9))
        0:       s = 7'h00;
        1, 2:    s = 7'($urandom);
        default: s = glyph[$urandom_range(0, 15)];
      endcase
      p = 1'($urandom);
      dwell = $urandom_range(1, 8);
      for (int i = 0; i < dwell; i++) begin
        // Occasional single-cycle dp flip exercises dp in the stability tuple.
        step(d, s, ($urandom_range(0, 15) == 0) ? ~p : p, ($urandom_range(0, 39) == 0));
        cyc++;
        n_vec++;
        if (upd !== m_upd || err !== m_err) begin
          n_err++;
          $display("FAIL rand_pulses: cycle %0d got upd=%b err=%b want upd=%b err=%b", cyc, upd,
                   err, m_upd, m_err);
        end
        n_vec++;
        if (value !== model_value() || digit_valid !== m_valid || dp_out !== m_dp) begin
          n_err++;
          $display("FAIL rand_state: cycle %0d got value=%h valid=%b dp=%b want %h %b %b", cyc,
                   value, digit_valid, dp_out, model_value(), m_valid, m_dp);
        end
        if (m_upd) begin
          n_vec++;
          if (int'(upd_idx) != m_idx) begin
            n_err++;
            $display("FAIL rand_idx: cycle %0d got idx=%0d want %0d", cyc, upd_idx, m_idx);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_invalid_blank();
    test_multihot_clr();
    test_full_scan();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
